// File: rtl/bip_cpu_if.sv
// Bus between the BIP-I core and its program ROM / data RAM.
// The master side is the CPU; the slave side is the memory subsystem.
interface bip_cpu_if #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16
);
    logic [NB_INSTRUC-1:0] i_instruc;
    logic [NB_DATA-1:0]    i_data_memory;
    logic [NB_ADDR-1:0]    o_addr_program_mem;
    logic [NB_ADDR-1:0]    o_addr_data_mem;
    logic [NB_DATA-1:0]    o_data_memory;
    logic                  o_WrRam;
    logic                  o_RdRam;

    modport master (
        input  i_instruc,
        input  i_data_memory,
        output o_addr_program_mem,
        output o_addr_data_mem,
        output o_data_memory,
        output o_WrRam,
        output o_RdRam
    );

    modport slave (
        output i_instruc,
        output i_data_memory,
        input  o_addr_program_mem,
        input  o_addr_data_mem,
        input  o_data_memory,
        input  o_WrRam,
        input  o_RdRam
    );
endinterface

// File: rtl/bip_cpu.sv
// Single-cycle BIP-I accumulator CPU: one instruction per clock, PC and ACC
// update on the rising edge, memory strobes decoded combinationally.
module bip_cpu #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bip_cpu_if.master     bus
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    logic [NB_ADDR-1:0]    pc_reg,  pc_next;
    logic [NB_DATA-1:0]    acc_reg, acc_next;
    logic [NB_OPCODE-1:0]  opcode;
    logic [NB_OPERAND-1:0] operand;
    logic [NB_DATA-1:0]    operand_ext;
    logic [NB_DATA-1:0]    alu_b;
    logic [NB_DATA-1:0]    alu_result;
    logic                  wr_en;
    logic                  rd_en;

    assign opcode  = bus.i_instruc[NB_INSTRUC-1 -: NB_OPCODE];
    assign operand = bus.i_instruc[NB_OPERAND-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NB_DATA; gi++) begin : g_sext
            if (gi < NB_OPERAND) begin : g_low
                assign operand_ext[gi] = operand[gi];
            end else begin : g_high
                assign operand_ext[gi] = operand[NB_OPERAND-1];
            end
        end
    endgenerate

    // Arithmetic opcodes share one adder: bit 0 selects the immediate operand,
    // bit 1 selects subtraction (ADD/ADDI/SUB/SUBI = 100/101/110/111).
    assign alu_b      = opcode[0] ? operand_ext : bus.i_data_memory;
    assign alu_result = opcode[1] ? (acc_reg - alu_b) : (acc_reg + alu_b);

    always_comb begin
        pc_next  = pc_reg + NB_ADDR'(1);
        acc_next = acc_reg;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        case (opcode)
            OP_HLT:  pc_next  = pc_reg;
            OP_STO:  wr_en    = 1'b1;
            OP_LD: begin
                rd_en    = 1'b1;
                acc_next = bus.i_data_memory;
            end
            OP_LDI:  acc_next = operand_ext;
            OP_ADD, OP_SUB: begin
                rd_en    = 1'b1;
                acc_next = alu_result;
            end
            OP_ADDI, OP_SUBI: acc_next = alu_result;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg  <= '0;
            acc_reg <= '0;
        end else begin
            pc_reg  <= pc_next;
            acc_reg <= acc_next;
        end
    end

    // Strobes are masked during reset so a stale instruction cannot touch RAM.
    assign bus.o_WrRam            = wr_en & ~i_rst;
    assign bus.o_RdRam            = rd_en & ~i_rst;
    assign bus.o_addr_program_mem = pc_reg;
    assign bus.o_addr_data_mem    = operand;
    assign bus.o_data_memory      = acc_reg;

endmodule

// File: tb/tb_bip_cpu.sv
// Scoreboard bench for bip_cpu: the stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the bus outputs.
module tb_bip_cpu;

    logic clk;
    logic rst;

    bip_cpu_if #(.NB_INSTRUC(16), .NB_ADDR(11), .NB_DATA(16)) bus ();

    bip_cpu #(
        .NB_INSTRUC(16), .NB_OPCODE(5), .NB_OPERAND(11), .NB_ADDR(11), .NB_DATA(16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] pc;
        logic [15:0] acc;
        logic        wr;
        logic        rd;
        logic [10:0] adr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Expectations describe the cycle just driven: PC/ACC as they stand
    // before the edge that executes ins, plus the strobes ins decodes to.
    task automatic cyc(input string name, input logic r, input logic [15:0] ins,
                       input logic [15:0] dm, input logic [10:0] epc,
                       input logic [15:0] eacc, input logic ewr, input logic erd);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        bus.i_instruc     = ins;
        bus.i_data_memory = dm;
        e.name = name;
        e.pc   = epc;
        e.acc  = eacc;
        e.wr   = ewr;
        e.rd   = erd;
        e.adr  = ins[10:0];
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.o_addr_program_mem === e.pc && bus.o_data_memory === e.acc &&
                bus.o_WrRam === e.wr && bus.o_RdRam === e.rd &&
                bus.o_addr_data_mem === e.adr && !(bus.o_WrRam && bus.o_RdRam)) begin
                passed++;
            end else begin
                $display("FAIL %s: got pc=%0d acc=%h wr=%b rd=%b adr=%h, expected pc=%0d acc=%h wr=%b rd=%b adr=%h",
                         e.name, bus.o_addr_program_mem, bus.o_data_memory, bus.o_WrRam,
                         bus.o_RdRam, bus.o_addr_data_mem, e.pc, e.acc, e.wr, e.rd, e.adr);
            end
        end
    end

    initial begin
        rst               = 1'b1;
        bus.i_instruc     = 16'h0FFF;
        bus.i_data_memory = 16'h0000;

        // reset with a STO opcode present: strobes must stay low
        cyc("rst0",     1'b1, 16'h0FFF, 16'h0000, 11'd0,  16'h0000, 1'b0, 1'b0);
        cyc("rst1",     1'b1, 16'h0FFF, 16'h0000, 11'd0,  16'h0000, 1'b0, 1'b0);
        cyc("nop0",     1'b0, 16'h4000, 16'h0000, 11'd0,  16'h0000, 1'b0, 1'b0);
        cyc("nop1",     1'b0, 16'h4000, 16'h0000, 11'd1,  16'h0000, 1'b0, 1'b0);
        cyc("nop2",     1'b0, 16'h4000, 16'h0000, 11'd2,  16'h0000, 1'b0, 1'b0);
        // immediates
        cyc("ldi29",    1'b0, 16'h181D, 16'h0000, 11'd3,  16'h0000, 1'b0, 1'b0);
        cyc("addi29",   1'b0, 16'h281D, 16'h0000, 11'd4,  16'h001D, 1'b0, 1'b0);
        cyc("subi5",    1'b0, 16'h3805, 16'h0000, 11'd5,  16'h003A, 1'b0, 1'b0);
        cyc("ldi_m1",   1'b0, 16'h1FFF, 16'h0000, 11'd6,  16'h0035, 1'b0, 1'b0);
        // memory operands, RAM returns 100
        cyc("ld29",     1'b0, 16'h101D, 16'h0064, 11'd7,  16'hFFFF, 1'b0, 1'b1);
        cyc("add29",    1'b0, 16'h201D, 16'h0064, 11'd8,  16'h0064, 1'b0, 1'b1);
        cyc("sub29",    1'b0, 16'h301D, 16'h0064, 11'd9,  16'h00C8, 1'b0, 1'b1);
        cyc("sto29",    1'b0, 16'h081D, 16'h0064, 11'd10, 16'h0064, 1'b1, 1'b0);
        // halt is sticky while the instruction stays HLT
        cyc("hlt0",     1'b0, 16'h0000, 16'h0000, 11'd11, 16'h0064, 1'b0, 1'b0);
        cyc("hlt1",     1'b0, 16'h0000, 16'h0000, 11'd11, 16'h0064, 1'b0, 1'b0);
        cyc("hlt2",     1'b0, 16'h0000, 16'h0000, 11'd11, 16'h0064, 1'b0, 1'b0);
        cyc("ldi3ff",   1'b0, 16'h1BFF, 16'h0000, 11'd11, 16'h0064, 1'b0, 1'b0);
        cyc("subi3ff",  1'b0, 16'h3BFF, 16'h0000, 11'd12, 16'h03FF, 1'b0, 1'b0);
        cyc("ld7fff",   1'b0, 16'h1000, 16'h7FFF, 11'd13, 16'h0000, 1'b0, 1'b1);
        cyc("addi1",    1'b0, 16'h2801, 16'h0000, 11'd14, 16'h7FFF, 1'b0, 1'b0);
        cyc("ovf",      1'b0, 16'h4000, 16'h0000, 11'd15, 16'h8000, 1'b0, 1'b0);
        // mid-program reset with a LD present: no read strobe
        cyc("rst_ld",   1'b1, 16'h101D, 16'h0005, 11'd16, 16'h8000, 1'b0, 1'b0);
        cyc("rst_sto",  1'b1, 16'h0FFF, 16'h0005, 11'd0,  16'h0000, 1'b0, 1'b0);
        cyc("restart",  1'b0, 16'h4000, 16'h0000, 11'd0,  16'h0000, 1'b0, 1'b0);
        for (int k = 1; k < 2048; k++) begin
            cyc("nop_run", 1'b0, 16'h4000, 16'h0000, 11'(k), 16'h0000, 1'b0, 1'b0);
        end
        cyc("wrap0",    1'b0, 16'h4000, 16'h0000, 11'd0,  16'h0000, 1'b0, 1'b0);
        cyc("wrap1",    1'b0, 16'h4000, 16'h0000, 11'd1,  16'h0000, 1'b0, 1'b0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
